wptr_full_prog: RTL
===================

# wptr_full_prog

Write-side pointer and flag generator for the asynchronous FIFO. It is the parametrised successor to the basic write-pointer/full block. Besides the binary write address, Gray write pointer and registered full flag, it produces:
- a registered fill level,
- a runtime-programmable almost-full flag,
- a sticky overflow flag with software clear.

It sits entirely in the write clock domain. Its inputs are the local write request and the two-flop-synchronised Gray read pointer. Its outputs drive the dual-port RAM write address and the write-to-read pointer synchroniser.

## Interface
- ADDR_WIDTH, 4, RAM address width; DEPTH = 2**ADDR_WIDTH; legal range ADDR_WIDTH >= 2
- wclk  in  1  write-domain clock; all state updates on its rising edge
- wrst_n  in  1  synchronous, active-low reset, sampled on rising wclk
- winc  in  1  write request for the current cycle
- wq2_rptr  in  ADDR_WIDTH+1  Gray read pointer, already synchronised into wclk
- wafull_thresh  in  ADDR_WIDTH+1  almost-full threshold in words; 0 disables wafull
- wovf_clr  in  1  one-cycle pulse that clears woverflow
- waddr  out  ADDR_WIDTH  RAM write address = wbin[ADDR_WIDTH-1:0]
- wptr  out  ADDR_WIDTH+1  registered Gray write pointer
- wfull  out  1  registered full flag
- wafull  out  1  registered almost-full flag
- wlevel  out  ADDR_WIDTH+1  registered fill level, 0..DEPTH
- woverflow  out  1  sticky: a write was attempted while full

## Operation
- **Write acceptance:** a write is accepted when `winc & ~wfull`. Writes attempted while full are dropped: no pointer change, no RAM write implied.
- **Binary pointer:** wbinnext = wbin + accepted, modulo 2**(ADDR_WIDTH+1). Wrap from all-ones to 0 is natural.
- **Gray pointer:** wgraynext = (wbinnext >> 1) ^ wbinnext; wptr <= wgraynext.
- **Read-pointer conversion:** rbin = Gray-to-binary of wq2_rptr, combinational. rbin[i] = XOR of wq2_rptr[ADDR_WIDTH:i].
- **Level:** level_next = (wbinnext - rbin) modulo 2**(ADDR_WIDTH+1); wlevel <= level_next.
- **Full:** wfull <= (wgraynext == {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq2_rptr[ADDR_WIDTH-2:0]}). This is equivalent to level_next == DEPTH. The verification bench checks both forms agree.
- **Almost-full:** wafull <= (wafull_thresh != 0) && (level_next >= wafull_thresh). A threshold greater than DEPTH means wafull never asserts.
- **Overflow:** woverflow <= (winc & wfull) | (woverflow & ~wovf_clr). If set and clear occur in the same cycle, set wins.
- **Reset:** when wrst_n = 0 at a rising edge, wbin, wptr, wlevel, wfull, wafull and woverflow all go to 0, so waddr = 0. Reset overrides all other inputs, including winc.
- **Mid-operation reset:** the pointer and flags return to 0 in one edge. The read side is reset by its own controller; this block does not coordinate the two resets.
- **Pessimistic view:** wlevel and wfull are deliberately conservative, since wq2_rptr lags the true read pointer by the synchroniser delay. Reads free space only after that latency.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- An accepted write at edge N gives updated waddr, wptr and wlevel visible after edge N.
- wfull asserts after the same edge that accepts the DEPTH-th outstanding word. The next cycle's winc is therefore already blocked.
- A change on wq2_rptr is reflected in wfull, wafull and wlevel after the next edge (latency 1).
- A change on wafull_thresh takes effect on wafull after the next edge.
- Exactly one Gray bit of wptr changes per accepted write.

## Test plan
- **Reset then idle:** hold wrst_n = 0 for 2 cycles, then release with winc = 0 and wq2_rptr = 0 → all outputs 0 and stay 0.
- **Fill:** ADDR_WIDTH = 4, wq2_rptr = 0, winc = 1 for 20 cycles → waddr counts 0..15, wlevel reaches 16, wfull = 1 after the 16th accepted write, wptr = 5'b11000, woverflow = 1 from the 17th attempt.
- **Almost-full:** wafull_thresh = 12, write 11 words → wafull = 0. Write the 12th word → wafull = 1. Set wafull_thresh = 0 → wafull = 0 the next cycle.
- **Drain release:** from full, set wq2_rptr to Gray(3) = 5'b00010 → wlevel = 13, wfull = 0 one cycle later. The next winc is accepted with waddr = 0.
- **Wrap:** write and advance wq2_rptr continuously for 40 words → wptr wraps through 5'b10000 and back to 0, every transition is single-bit, and wfull never asserts.
- **Overflow clear and reset:** assert wovf_clr together with winc while full → woverflow stays 1. Assert wovf_clr alone → woverflow = 0. Assert wrst_n = 0 while wlevel = 9 → all outputs 0 after one edge.

Source files
------------

// File: rtl/wptr_full_prog.sv
// Write-domain pointer and flag generator for an asynchronous FIFO: binary/Gray
// write pointer, registered full, programmable almost-full, fill level and sticky overflow.
module wptr_full_prog #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic                  winc,
    input  logic [ADDR_WIDTH:0]   wq2_rptr,
    input  logic [ADDR_WIDTH:0]   wafull_thresh,
    input  logic                  wovf_clr,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic                  wfull,
    output logic                  wafull,
    output logic [ADDR_WIDTH:0]   wlevel,
    output logic                  woverflow
);

    logic [ADDR_WIDTH:0] wbin;
    logic [ADDR_WIDTH:0] wbinnext;
    logic [ADDR_WIDTH:0] wgraynext;
    logic [ADDR_WIDTH:0] rbin;
    logic [ADDR_WIDTH:0] level_next;
    logic                accepted;
    logic                full_next;
    logic                afull_next;
    logic                ovf_next;

    assign accepted  = winc & ~wfull;
    assign wbinnext  = wbin + {{ADDR_WIDTH{1'b0}}, accepted};
    assign wgraynext = (wbinnext >> 1) ^ wbinnext;

    // Gray-to-binary: each bit is the XOR of all Gray bits at or above it.
    always_comb begin
        rbin = '0;
        rbin[ADDR_WIDTH] = wq2_rptr[ADDR_WIDTH];
        for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
            rbin[i] = rbin[i+1] ^ wq2_rptr[i];
        end
    end

    assign level_next = wbinnext - rbin;

    // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
    assign full_next  = (wgraynext == {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1],
                                        wq2_rptr[ADDR_WIDTH-2:0]});
    assign afull_next = (wafull_thresh != '0) && (level_next >= wafull_thresh);
    assign ovf_next   = (winc & wfull) | (woverflow & ~wovf_clr);

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wbin      <= '0;
            wptr      <= '0;
            wlevel    <= '0;
            wfull     <= 1'b0;
            wafull    <= 1'b0;
            woverflow <= 1'b0;
        end else begin
            wbin      <= wbinnext;
            wptr      <= wgraynext;
            wlevel    <= level_next;
            wfull     <= full_next;
            wafull    <= afull_next;
            woverflow <= ovf_next;
        end
    end

    assign waddr = wbin[ADDR_WIDTH-1:0];

endmodule
